// File: rtl/ttt_board_judge.sv
// ttt_board_judge: owns the 3x3 tic-tac-toe board, judges each granted move,
// and reports ill_move / no_space / win back to the turn controller.
// A move accepted in cycle N has its board write, move_done, win/no_space and
// the first ill_move cycle all visible at N+2. To achieve that, the line
// evaluation runs on the next-board value during S_CHECK, and its results are
// registered so they are presented while the FSM sits in S_EVAL.
// Optional macro JUDGE_MOVE_CNT_EN adds a saturating move_count output.
module ttt_board_judge #(
    parameter int ILL_HOLD = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p1_play,
    input  logic        p2_play,
    input  logic        move_valid,
    input  logic [3:0]  move_pos,
    output logic        ill_move,
    output logic        no_space,
    output logic        win,
    output logic [1:0]  winner,
    output logic        move_done,
    output logic        busy,
`ifdef JUDGE_MOVE_CNT_EN
    output logic [3:0]  move_count,
`endif
    output logic [17:0] board
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_EVAL,
        S_ILL,
        S_OVER
    } state_t;

    state_t      state;
    logic [3:0]  move_pos_p0;
    logic [1:0]  mover_p0;
    logic [3:0]  ill_cnt;

    logic        accept;
    logic        pos_ok;
    logic [3:0]  idx;
    logic        target_free;
    logic [17:0] board_next;
    logic        next_win;
    logic        next_full;

    // Contents of cell i of a packed board.
    function automatic logic [1:0] cell_at(input logic [17:0] b, input int i);
        return b[2*i +: 2];
    endfunction

    // True when cells a, b, c hold the same nonzero owner.
    function automatic logic line_hit(input logic [17:0] b, input int a,
                                      input int c1, input int c2);
        return (cell_at(b, a) != 2'b00) &&
               (cell_at(b, a) == cell_at(b, c1)) &&
               (cell_at(b, a) == cell_at(b, c2));
    endfunction

    // Any of the eight winning lines complete.
    function automatic logic any_line(input logic [17:0] b);
        return line_hit(b, 0, 1, 2) || line_hit(b, 3, 4, 5) ||
               line_hit(b, 6, 7, 8) || line_hit(b, 0, 3, 6) ||
               line_hit(b, 1, 4, 7) || line_hit(b, 2, 5, 8) ||
               line_hit(b, 0, 4, 8) || line_hit(b, 2, 4, 6);
    endfunction

    // Every cell occupied.
    function automatic logic all_full(input logic [17:0] b);
        logic full;
        full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (cell_at(b, i) == 2'b00) full = 1'b0;
        end
        return full;
    endfunction

    // Legality of the latched move and the board it would produce.
    always_comb begin
        accept      = move_valid && (p1_play ^ p2_play);
        pos_ok      = (move_pos_p0 <= 4'd8);
        idx         = pos_ok ? move_pos_p0 : 4'd0;
        target_free = pos_ok && (cell_at(board, int'(idx)) == 2'b00);
        board_next  = board;
        board_next[2*int'(idx) +: 2] = mover_p0;
        next_win    = any_line(board_next);
        next_full   = all_full(board_next);
    end

    // Judge FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            move_pos_p0 <= 4'd0;
            mover_p0    <= 2'b00;
            ill_cnt     <= 4'd0;
            ill_move    <= 1'b0;
            no_space    <= 1'b0;
            win         <= 1'b0;
            winner      <= 2'b00;
            move_done   <= 1'b0;
            busy        <= 1'b0;
            board       <= 18'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        move_pos_p0 <= move_pos;
                        mover_p0    <= p1_play ? 2'b01 : 2'b10;
                        busy        <= 1'b1;
                        state       <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (target_free) begin
                        board     <= board_next;
                        move_done <= 1'b1;
                        if (next_win) begin
                            win    <= 1'b1;
                            winner <= mover_p0;
                        end else if (next_full) begin
                            no_space <= 1'b1;
                        end
                        state <= S_EVAL;
                    end else begin
                        ill_move <= 1'b1;
                        ill_cnt  <= 4'(ILL_HOLD - 1);
                        state    <= S_ILL;
                    end
                end
                S_EVAL: begin
                    move_done <= 1'b0;
                    if (win || no_space) begin
                        state <= S_OVER;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_ILL: begin
                    if (ill_cnt == 4'd0) begin
                        ill_move <= 1'b0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        ill_cnt <= ill_cnt - 4'd1;
                    end
                end
                S_OVER: begin
                    state <= S_OVER;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef JUDGE_MOVE_CNT_EN
    // Count committed legal moves, saturating at a full board.
    always_ff @(posedge clk) begin
        if (reset) begin
            move_count <= 4'd0;
        end else if (state == S_EVAL && move_count != 4'd9) begin
            move_count <= move_count + 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ttt_board_judge.sv
// Bench for ttt_board_judge: directed test-plan scenarios followed by random
// games, all checked against a cell-array game model.
module tb_ttt_board_judge;

    localparam int ILL_HOLD = 2;

    logic        clk;
    logic        reset;
    logic        p1_play;
    logic        p2_play;
    logic        move_valid;
    logic [3:0]  move_pos;
    logic        ill_move;
    logic        no_space;
    logic        win;
    logic [1:0]  winner;
    logic        move_done;
    logic        busy;
    logic [17:0] board;
`ifdef JUDGE_MOVE_CNT_EN
    logic [3:0]  move_count;
`endif

    ttt_board_judge #(.ILL_HOLD(ILL_HOLD)) dut (
        .clk        (clk),
        .reset      (reset),
        .p1_play    (p1_play),
        .p2_play    (p2_play),
        .move_valid (move_valid),
        .move_pos   (move_pos),
        .ill_move   (ill_move),
        .no_space   (no_space),
        .win        (win),
        .winner     (winner),
        .move_done  (move_done),
        .busy       (busy),
`ifdef JUDGE_MOVE_CNT_EN
        .move_count (move_count),
`endif
        .board      (board)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Game model: owner per cell (0 empty, 1 P1, 2 P2).
    int m_cell[9];
    int m_over;
    int m_win;
    int m_winner;
    int m_full;
    int m_cnt;
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [17:0] model_board();
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_cell[i]);
        return b;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 9; i++) m_cell[i] = 0;
        m_over = 0; m_win = 0; m_winner = 0; m_full = 0; m_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        move_valid = 1'b0; p1_play = 1'b0; p2_play = 1'b0; move_pos = 4'd0;
        tick();
        tick();
        reset = 1'b0;
        model_clear();
        chk("rst_board", 32'(board), 32'd0);
        chk("rst_flags", {26'd0, ill_move, no_space, win, move_done, busy, 1'b0}, 32'd0);
        chk("rst_winner", 32'(winner), 32'd0);
`ifdef JUDGE_MOVE_CNT_EN
        chk("rst_count", 32'(move_count), 32'd0);
`endif
    endtask

    // kind: 0 ignored, 1 illegal, 2 legal
    task automatic apply_move(input logic g1, input logic g2, input int pos);
        int kind;
        int mover;
        logic busy_before;
        busy_before = busy;
        if (m_over != 0 || (g1 == g2)) kind = 0;
        else if (pos > 8) kind = 1;
        else if (m_cell[pos] != 0) kind = 1;
        else kind = 2;
        mover = g1 ? 1 : 2;
        if (kind == 2) begin
            m_cell[pos] = mover;
            for (int l = 0; l < 8; l++) begin
                if (m_cell[lines[l][0]] != 0 &&
                    m_cell[lines[l][0]] == m_cell[lines[l][1]] &&
                    m_cell[lines[l][0]] == m_cell[lines[l][2]]) m_win = 1;
            end
            if (m_win != 0) m_winner = mover;
            else begin
                m_full = 1;
                for (int i = 0; i < 9; i++) if (m_cell[i] == 0) m_full = 0;
            end
            if (m_win != 0 || m_full != 0) m_over = 1;
            if (m_cnt < 9) m_cnt++;
        end
        p1_play = g1; p2_play = g2; move_valid = 1'b1; move_pos = 4'(pos);
        tick();
        move_valid = 1'b0; p1_play = 1'b0; p2_play = 1'b0;
        chk("busy_n1", 32'(busy), (kind == 0) ? 32'(busy_before) : 32'd1);
        tick();
        chk("board_n2", 32'(board), 32'(model_board()));
        chk("done_n2", 32'(move_done), (kind == 2) ? 32'd1 : 32'd0);
        chk("ill_n2", 32'(ill_move), (kind == 1) ? 32'd1 : 32'd0);
        chk("win_n2", 32'(win), 32'(m_win));
        chk("winner_n2", 32'(winner), 32'(m_winner));
        chk("nospace_n2", 32'(no_space), 32'(m_full));
        if (kind == 1) begin
            for (int k = 1; k < ILL_HOLD; k++) begin
                tick();
                chk("ill_hold", 32'(ill_move), 32'd1);
                chk("ill_nodone", 32'(move_done), 32'd0);
            end
            tick();
            chk("ill_end", 32'(ill_move), 32'd0);
            chk("ill_idle", 32'(busy), 32'd0);
            chk("ill_board", 32'(board), 32'(model_board()));
        end else if (kind == 2) begin
            tick();
            chk("done_pulse", 32'(move_done), 32'd0);
            chk("busy_after", 32'(busy), 32'(m_over));
`ifdef JUDGE_MOVE_CNT_EN
            chk("move_count", 32'(move_count), 32'(m_cnt));
`endif
        end else begin
            chk("ign_busy", 32'(busy), 32'(busy_before));
        end
    endtask

    initial begin
        reset = 1'b1; move_valid = 1'b0; p1_play = 1'b0; p2_play = 1'b0; move_pos = 4'd0;
        model_clear();
        @(negedge clk);
        do_reset();

        // First move, then an occupied cell, out-of-range cell, double grant.
        apply_move(1'b1, 1'b0, 4);
        chk("cell4_p1", 32'(board[9:8]), 32'd1);
        apply_move(1'b0, 1'b1, 4);
        apply_move(1'b1, 1'b0, 11);
        apply_move(1'b1, 1'b1, 0);
        apply_move(1'b0, 1'b0, 0);

        // Top-row win for P1, then a move into the finished game.
        do_reset();
        apply_move(1'b1, 1'b0, 0);
        apply_move(1'b0, 1'b1, 3);
        apply_move(1'b1, 1'b0, 1);
        apply_move(1'b0, 1'b1, 4);
        apply_move(1'b1, 1'b0, 2);
        chk("p1_win", 32'(win), 32'd1);
        chk("p1_winner", 32'(winner), 32'd1);
        apply_move(1'b0, 1'b1, 8);
        chk("over_busy", 32'(busy), 32'd1);

        // Draw game.
        do_reset();
        apply_move(1'b1, 1'b0, 0);
        apply_move(1'b0, 1'b1, 2);
        apply_move(1'b1, 1'b0, 1);
        apply_move(1'b0, 1'b1, 3);
        apply_move(1'b1, 1'b0, 5);
        apply_move(1'b0, 1'b1, 4);
        apply_move(1'b1, 1'b0, 6);
        apply_move(1'b0, 1'b1, 7);
        apply_move(1'b1, 1'b0, 8);
        chk("draw_nospace", 32'(no_space), 32'd1);
        chk("draw_nowin", 32'(win), 32'd0);
`ifdef JUDGE_MOVE_CNT_EN
        chk("draw_count9", 32'(move_count), 32'd9);
`endif

        // Reset landing in the S_CHECK cycle of a legal move.
        do_reset();
        p1_play = 1'b1; move_valid = 1'b1; move_pos = 4'd6;
        tick();
        move_valid = 1'b0; p1_play = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_board", 32'(board), 32'd0);
        chk("abort_flags", {27'd0, ill_move, no_space, win, move_done, busy}, 32'd0);
        tick();
        chk("abort_noflag", {28'd0, move_done, win, no_space, busy}, 32'd0);
        model_clear();
        apply_move(1'b0, 1'b1, 6);

        // Random games.
        do_reset();
        for (int it = 0; it < 400; it++) begin
            logic g1, g2;
            int pos;
            g1 = 1'($urandom_range(0, 1));
            g2 = ($urandom_range(0, 3) == 0) ? g1 : ~g1;
            pos = $urandom_range(0, 11);
            apply_move(g1, g2, pos);
            chk("no_ill_done", 32'(ill_move & move_done), 32'd0);
            if (m_over != 0 && $urandom_range(0, 1) == 1) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ttt_board_judge.md
Name: ttt_board_judge

Overview:
- Board-side counterpart of the turn controller. Consumes the controller's p1_play/p2_play turn grants and the player move requests.
- Owns the 3x3 board state and judges each move.
- Returns ill_move, no_space and win to the turn controller.
- Also exposes the packed board for the display path.

Parameters:
- ILL_HOLD, 2, number of cycles ill_move stays asserted after a rejected move (1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- p1_play  in  1  turn grant for player 1, from the turn controller.
- p2_play  in  1  turn grant for player 2, from the turn controller.
- move_valid  in  1  single-cycle move request strobe.
- move_pos  in  4  target cell, 0..8, row-major (0 = top-left, 8 = bottom-right).
- ill_move  out  1  rejected move; held for ILL_HOLD cycles.
- no_space  out  1  board full with no winner; sticky until reset.
- win  out  1  three-in-a-row formed; sticky until reset.
- winner  out  2  01 = P1, 10 = P2, 00 = none.
- move_done  out  1  1-cycle pulse when a legal move is committed and evaluated.
- busy  out  1  high whenever the FSM is not in S_IDLE.
- board  out  18  packed board; cell i is board[2i+1:2i]; 00 = empty, 01 = P1, 10 = P2.

Behaviour:
- Reset: all outputs 0, board all 00, state S_IDLE. Reset mid-move aborts the move; no partial write occurs.
- States: S_IDLE, S_CHECK, S_EVAL, S_ILL, S_OVER.
- S_IDLE: a move is accepted when move_valid=1 and exactly one of p1_play/p2_play=1.
  - On accept, latch move_pos and the mover (P1 if p1_play, else P2), then go to S_CHECK.
  - move_valid with both grants high or both low is ignored, state unchanged.
- S_CHECK (1 cycle):
  - Illegal if move_pos>8 or the target cell is not 00. Board unchanged; go to S_ILL.
  - Legal: write 01 (P1) or 10 (P2) into the cell; go to S_EVAL.
- S_ILL: ill_move=1 for exactly ILL_HOLD cycles, then ill_move=0 and return to S_IDLE. No move_done pulse.
- S_EVAL (1 cycle), evaluated on the updated board:
  - Check 8 lines: rows {0,1,2},{3,4,5},{6,7,8}; columns {0,3,6},{1,4,7},{2,5,8}; diagonals {0,4,8},{2,4,6}.
  - Line win: all three cells equal and nonzero.
  - win=1 with winner = mover if any line wins.
  - Else no_space=1 if all 9 cells are nonzero.
  - move_done pulses this cycle's registered output.
  - Next state: S_OVER if win or no_space, else S_IDLE.
- Simultaneous win and full board (winning last cell): win=1, no_space=0.
- S_OVER: win/no_space/winner/board frozen; all move_valid ignored; left only by reset.
- Latency: move_valid accepted in cycle N.
  - Board write visible at N+2.
  - move_done, win, no_space, and the first ill_move cycle all visible at N+2 (registered outputs).
- move_valid while busy=1 is dropped; there is no queue.
- ill_move is never asserted in the same cycle as move_done.

Optional Feature:
- Macro JUDGE_MOVE_CNT_EN.
- When defined: adds output port move_count (4 bits).
  - Counts committed legal moves: increments in S_EVAL, saturates at 9, reset clears it to 0.
  - Illegal moves do not increment it.
- When undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset, p1_play=1, move_valid with move_pos=4 -> board[9:8]=01 at N+2, move_done pulse, ill_move=0, win=0.
- Cell 4 held by P1, p2_play=1, move_pos=4 -> ill_move high 2 cycles (ILL_HOLD=2), board unchanged, no move_done.
- p1_play=1, move_pos=11 -> ill_move asserted; both grants high plus move_valid -> request ignored, busy stays 0.
- Alternate moves P1:0, P2:3, P1:1, P2:4, P1:2 -> after the last move win=1, winner=01, state S_OVER; a further move_valid with p2_play=1 is ignored.
- Fill the board with no line: P1 0,1,5,6,8 and P2 2,3,4,7 -> no_space=1, win=0 after the 9th move; with JUDGE_MOVE_CNT_EN, move_count=9.
- Assert reset in the S_CHECK cycle of a legal move -> board=0, all outputs 0, next move accepted normally.
